// File: rtl/cacheline_adapter_types.sv
// Shared types and constants for the cacheline adapter: line/beat geometry and the FSM state enum.
package cacheline_adapter_types;

    localparam int unsigned LINE_W      = 256;
    localparam int unsigned BEAT_W      = 64;
    localparam int unsigned BEATS       = 4;
    localparam int unsigned OFFSET_BITS = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        RESP
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Serves one 256-bit cacheline read/write from the cache as a 4-beat burst on 64-bit memory.
// Optional CACHELINE_ADAPTER_RADDR_CHECK_EN: only count read beats whose bmem_raddr matches.
module cacheline_adapter
    import cacheline_adapter_types::*;
(
    input  logic                clk,
    input  logic                rst,

    input  logic [31:0]         dfp_addr,
    input  logic                dfp_read,
    input  logic                dfp_write,
    input  logic [LINE_W-1:0]   dfp_wdata,
    output logic [LINE_W-1:0]   dfp_rdata,
    output logic                dfp_resp,

    output logic [31:0]         bmem_addr,
    output logic                bmem_read,
    output logic                bmem_write,
    output logic [BEAT_W-1:0]   bmem_wdata,
    input  logic                bmem_ready,
    input  logic [31:0]         bmem_raddr,
    input  logic [BEAT_W-1:0]   bmem_rdata,
    input  logic                bmem_rvalid
);

    adapter_state_t      state_q, state_d;
    logic [31:0]         addr_q;
    logic [LINE_W-1:0]   line_q;
    logic [1:0]          cnt_q;
    logic                wr_q;
    logic                beat_hit;
    logic                unused_bits;

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    assign beat_hit    = bmem_rvalid && (bmem_raddr == addr_q);
    assign unused_bits = ^dfp_addr[OFFSET_BITS-1:0];
`else
    assign beat_hit    = bmem_rvalid;
    assign unused_bits = ^{bmem_raddr, dfp_addr[OFFSET_BITS-1:0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        dfp_resp   = 1'b0;
        dfp_rdata  = '0;
        unique case (state_q)
            IDLE: begin
                // Write has priority if the cache raises both.
                if (dfp_write) begin
                    state_d = WR_DATA;
                end else if (dfp_read) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
                if (bmem_ready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (beat_hit && cnt_q == 2'd3) begin
                    state_d = RESP;
                end
            end
            WR_DATA: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = line_q[BEAT_W*cnt_q +: BEAT_W];
                if (bmem_ready && cnt_q == 2'd3) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                dfp_resp = 1'b1;
                if (!wr_q) begin
                    dfp_rdata = line_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            line_q <= '0;
            cnt_q  <= '0;
            wr_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (dfp_write || dfp_read) begin
                        addr_q <= {dfp_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        cnt_q  <= '0;
                        wr_q   <= dfp_write;
                    end
                    if (dfp_write) begin
                        line_q <= dfp_wdata;
                    end
                end
                RD_DATA: begin
                    if (beat_hit) begin
                        line_q[BEAT_W*cnt_q +: BEAT_W] <= bmem_rdata;
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                WR_DATA: begin
                    if (bmem_ready) begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Bench for cacheline_adapter: directed table of transactions plus random ones against a
// transaction-level timing/data model; a memory responder drives the bmem side.
module tb_cacheline_adapter;
    import cacheline_adapter_types::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        dfp_addr;
    logic               dfp_read, dfp_write;
    logic [255:0]       dfp_wdata, dfp_rdata;
    logic               dfp_resp;
    logic [31:0]        bmem_addr;
    logic               bmem_read, bmem_write;
    logic [63:0]        bmem_wdata;
    logic               bmem_ready;
    logic [31:0]        bmem_raddr;
    logic [63:0]        bmem_rdata;
    logic               bmem_rvalid;

    int checks = 0;
    int errors = 0;

    cacheline_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        bit           both;
        bit           hold;
        logic [31:0]  addr;
        logic [255:0] line;
        bit [63:0]    rdy;    // bmem_ready per cycle (cycle 0 = request cycle)
        bit [63:0]    val;    // good beat offered per cycle once the burst is accepted
        bit [63:0]    bad;    // foreign-address beat offered per cycle
        int           exp_resp;
        logic [31:0]  exp_baddr;
        logic [255:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit pat(bit [63:0] p, int c);
        return (c > 63) ? 1'b1 : p[c];
    endfunction

    // Cycle in which dfp_resp is expected, from the ready/beat schedule alone.
    function automatic int model_resp(bit wr, bit [63:0] rdy, bit [63:0] val, bit [63:0] bad);
        int n = 0;
        int a = -1;
        for (int c = 1; c < 200; c++) begin
            if (wr) begin
                if (pat(rdy, c)) begin
                    n++;
                    if (n == 4) return c + 1;
                end
            end else if (a < 0) begin
                if (pat(rdy, c)) a = c;
            end else if (c < 64 && bad[c]) begin
`ifndef CACHELINE_ADAPTER_RADDR_CHECK_EN
                n++;
                if (n == 4) return c + 1;
`endif
            end else if (pat(val, c)) begin
                n++;
                if (n == 4) return c + 1;
            end
        end
        return -1;
    endfunction

    function automatic vec_t mk(bit wr, bit both, bit hold, logic [31:0] addr, logic [255:0] line,
                                bit [63:0] rdy, bit [63:0] val, bit [63:0] bad);
        vec_t v;
        v.wr        = wr;
        v.both      = both;
        v.hold      = hold;
        v.addr      = addr;
        v.line      = line;
        v.rdy       = rdy;
        v.val       = val;
        v.bad       = bad;
        v.exp_resp  = model_resp(wr, rdy, val, bad);
        v.exp_baddr = addr & 32'hFFFF_FFE0;
        v.exp_rdata = wr ? 256'd0 : line;
        return v;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    // Entered and left 1 time unit after a rising edge with the DUT idle.
    task automatic run_vec(input vec_t v, input string tag);
        int resp_cyc = -1;
        int resp_n = 0;
        int acc_reads = 0;
        int rd_seen = 0;
        int good = 0;
        int wr_bus = 0;
        int hold_bad = 0;
        bit accepted = 1'b0;
        bit addr_ok = 1'b1;
        bit prev_stall = 1'b0;
        logic [63:0] prev_wd = '0;
        logic [255:0] rdata_at = '0;
        logic [63:0] wq[$];

        dfp_addr    = v.addr;
        dfp_wdata   = v.wr ? v.line : rand_line();
        dfp_write   = v.wr;
        dfp_read    = !v.wr || v.both;
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        for (int cyc = 1; cyc < 150; cyc++) begin
            @(posedge clk);
            #1;
            if (dfp_resp) begin
                resp_n++;
                if (resp_cyc < 0) begin
                    resp_cyc = cyc;
                    rdata_at = dfp_rdata;
                end
            end
            if ((bmem_read || bmem_write) && bmem_addr !== v.exp_baddr) addr_ok = 1'b0;
            if (bmem_read) rd_seen++;
            if (bmem_write) begin
                wr_bus++;
                if (prev_stall && bmem_wdata !== prev_wd) hold_bad++;
            end
            if (resp_cyc >= 0 && (!v.hold || cyc > resp_cyc)) begin
                dfp_read  = 1'b0;
                dfp_write = 1'b0;
            end
            bmem_ready  = pat(v.rdy, cyc);
            bmem_rvalid = 1'b0;
            bmem_raddr  = v.exp_baddr;
            bmem_rdata  = {$urandom, $urandom};
            if (accepted && good < 4) begin
                if (cyc < 64 && v.bad[cyc]) begin
                    bmem_rvalid = 1'b1;
                    bmem_raddr  = 32'hDEAD_BEE0;
                end else if (pat(v.val, cyc)) begin
                    bmem_rvalid = 1'b1;
                    bmem_rdata  = v.line[64*good +: 64];
                    good++;
                end
            end
            if (bmem_read && bmem_ready) begin
                accepted = 1'b1;
                acc_reads++;
            end
            if (bmem_write && bmem_ready) wq.push_back(bmem_wdata);
            prev_stall = bmem_write && !bmem_ready;
            prev_wd    = bmem_wdata;
            if (resp_cyc >= 0 && cyc >= resp_cyc + 3) break;
        end
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;

        chk({tag, " resp_cycle"}, resp_cyc, v.exp_resp);
        chk({tag, " resp_count"}, resp_n, 1);
        chk({tag, " bmem_addr"}, addr_ok, 1);
        chk({tag, " dfp_rdata"}, rdata_at, v.exp_rdata);
        if (v.wr) begin
            chk({tag, " wbeats"}, wq.size(), 4);
            for (int i = 0; i < 4 && i < wq.size(); i++) chk({tag, " wbeat"}, wq[i], v.line[64*i +: 64]);
            chk({tag, " rd_cycles"}, rd_seen, 0);
            chk({tag, " wr_cycles"}, wr_bus, v.exp_resp - 1);
            chk({tag, " wr_hold"}, hold_bad, 0);
        end else begin
            chk({tag, " rd_accepts"}, acc_reads, 1);
            chk({tag, " wr_cycles"}, wr_bus, 0);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " dfp_resp"}, dfp_resp, 0);
        chk({tag, " dfp_rdata"}, dfp_rdata, 0);
        chk({tag, " bmem_read"}, bmem_read, 0);
        chk({tag, " bmem_write"}, bmem_write, 0);
        chk({tag, " bmem_addr"}, bmem_addr, 0);
        chk({tag, " bmem_wdata"}, bmem_wdata, 0);
    endtask

    initial begin
        logic [255:0] seq_line;
        logic [255:0] wr_line;
        int stray_resp;

        seq_line = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                    64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};
        wr_line  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

        rst = 1'b1;
        dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        vecs.push_back(mk(0, 0, 0, 32'h0000_1234, seq_line, '1, '1, '0));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0047, wr_line, ~64'h4, '1, '0));
        vecs.push_back(mk(0, 0, 1, 32'h0000_5A5F, rand_line(), ~64'h2, 64'h990, '0));
        vecs.push_back(mk(1, 1, 0, 32'hCAFE_F00D, rand_line(), '1, '1, '0));
        vecs.push_back(mk(1, 0, 1, 32'h1234_5678, rand_line(), ~64'h6, '1, '0));
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
        vecs.push_back(mk(0, 0, 0, 32'h0000_2000, rand_line(), '1, 64'h74, 64'h8));
`endif
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset after the second read beat, with two trailing beats afterwards.
        dfp_addr = 32'h0000_4440;
        dfp_read = 1'b1;
        stray_resp = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk);
            #1;
            if (dfp_resp) stray_resp++;
            if (cyc == 5) chk_outputs_zero("mid_reset");
            bmem_ready  = (cyc == 1);
            bmem_rvalid = (cyc == 2 || cyc == 3 || cyc == 5 || cyc == 6);
            bmem_raddr  = 32'h0000_4440;
            bmem_rdata  = {$urandom, $urandom};
            rst         = (cyc == 4);
            if (cyc == 4) dfp_read = 1'b0;
            if (cyc >= 6) chk($sformatf("post_reset c%0d bmem_read", cyc), bmem_read, 0);
        end
        bmem_rvalid = 1'b0;
        bmem_ready  = 1'b0;
        chk("post_reset stray_resp", stray_resp, 0);
        run_vec(mk(0, 0, 0, 32'h0000_4440, rand_line(), ~64'h2, '1, '0), "after_reset");

        for (int n = 0; n < 40; n++) begin
            bit wr;
            wr = $urandom_range(0, 1) == 1;
            run_vec(mk(wr, wr && ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, $urandom,
                       rand_line(), {$urandom | $urandom, $urandom | $urandom},
                       {$urandom | $urandom, $urandom | $urandom}, '0),
                    $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
